// File: rtl/gw5ast_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gw5ast_axil_pkg
//  Description : Shared AXI-Lite response codes and strobe width for the
//                gw5ast memory responder and its SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package gw5ast_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam int         STRB_W      = 4;

endpackage : gw5ast_axil_pkg
`default_nettype wire

// File: rtl/gw5ast_sram_1r1w.sv
`default_nettype none
// ============================================================================
//  Module      : gw5ast_sram_1r1w
//  Description : Synchronous 1-read/1-write SRAM with per-byte write enables.
//                A read and write to the same address in the same cycle
//                returns the old contents. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module gw5ast_sram_1r1w #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                            clk,
   input  logic [((DATA_WIDTH+7)/8)-1:0]   wr_be,
   input  logic [DEPTH_LOG2-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            rd_en,
   input  logic [DEPTH_LOG2-1:0]           rd_addr,
   output logic [DATA_WIDTH-1:0]           rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Byte-masked write and registered read; non-blocking updates give
   // read-before-write ordering on an address collision.
   always_ff @(posedge clk) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if (wr_be[b/8]) begin
            mem[wr_addr][b] <= wr_data[b];
         end
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : gw5ast_sram_1r1w
`default_nettype wire

// File: rtl/gw5ast_axil_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : gw5ast_axil_mem_slave
//  Description : Single-beat AXI-Lite responder backed by a byte-writable
//                SRAM. Independent read and write channels, one outstanding
//                transaction each. Out-of-range accesses answer SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module gw5ast_axil_mem_slave
   import gw5ast_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   axi_awvalid,
   output logic                   axi_awready,
   input  logic [ADDR_WIDTH-1:0]  axi_awaddr,
   input  logic                   axi_wvalid,
   output logic                   axi_wready,
   input  logic [DATA_WIDTH-1:0]  axi_wdata,
   input  logic [STRB_W-1:0]      axi_wstrb,
   input  logic                   axi_wlast,
   output logic                   axi_bvalid,
   input  logic                   axi_bready,
   output logic [1:0]             axi_bresp,
   input  logic                   axi_arvalid,
   output logic                   axi_arready,
   input  logic [ADDR_WIDTH-1:0]  axi_araddr,
   output logic                   axi_rvalid,
   input  logic                   axi_rready,
   output logic [DATA_WIDTH-1:0]  axi_rdata,
   output logic [1:0]             axi_rresp,
   output logic                   axi_rlast
);

   localparam int LANES = (DATA_WIDTH + 7) / 8;

   logic                  aw_held, w_held, bvalid_q, rvalid_q, rd_oor_q;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q, sram_rdata;
   logic [LANES-1:0]      w_strb_q, wr_be;
   logic [1:0]            bresp_q, rresp_q;
   logic [DEPTH_LOG2-1:0] wr_mem_addr, rd_mem_addr;
   logic                  wr_in_range, rd_in_range;
   logic                  awready_int, wready_int, arready_int;
   logic                  aw_hs, w_hs, ar_hs, commit;
   logic                  unused_ok;

   // wlast is constant 1 for single beats; strobe bit 3 has no lane.
   assign unused_ok = &{1'b0, axi_wlast, axi_wstrb};

   // Readies depend on registered state only, never on the valids.
   assign awready_int = rst_n & ~aw_held & ~bvalid_q;
   assign wready_int  = rst_n & ~w_held  & ~bvalid_q;
   assign arready_int = rst_n & ~rvalid_q;

   assign aw_hs  = axi_awvalid & awready_int;
   assign w_hs   = axi_wvalid  & wready_int;
   assign ar_hs  = axi_arvalid & arready_int;
   assign commit = aw_held & w_held;

   // Address decode: a narrow address bus is always fully in range.
   if (DEPTH_LOG2 >= ADDR_WIDTH) begin : g_range_all
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
      assign wr_mem_addr = DEPTH_LOG2'(aw_addr_q);
      assign rd_mem_addr = DEPTH_LOG2'(axi_araddr);
   end else begin : g_range_chk
      assign wr_in_range = (aw_addr_q[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
      assign rd_in_range = (axi_araddr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
      assign wr_mem_addr = aw_addr_q[DEPTH_LOG2-1:0];
      assign rd_mem_addr = axi_araddr[DEPTH_LOG2-1:0];
   end

   assign wr_be = (commit && wr_in_range) ? w_strb_q : '0;

   // Write-channel control: holding flags, commit and response handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
         end
         if (w_hs) begin
            w_held <= 1'b1;
         end
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && axi_bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Write-channel payload capture; no reset needed on data.
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         aw_addr_q <= axi_awaddr;
      end
      if (w_hs) begin
         w_data_q <= axi_wdata;
         w_strb_q <= axi_wstrb[LANES-1:0];
      end
   end

   // Read-channel valid: set on AR handshake, cleared on R handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
      end else if (rvalid_q && axi_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // Read response attributes, held stable until the next AR handshake.
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         rd_oor_q <= ~rd_in_range;
         rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   gw5ast_sram_1r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_sram (
      .clk     (clk),
      .wr_be   (wr_be),
      .wr_addr (wr_mem_addr),
      .wr_data (w_data_q),
      .rd_en   (ar_hs),
      .rd_addr (rd_mem_addr),
      .rd_data (sram_rdata)
   );

   // Every output is forced low while reset is asserted.
   assign axi_awready = awready_int;
   assign axi_wready  = wready_int;
   assign axi_arready = arready_int;
   assign axi_bvalid  = rst_n & bvalid_q;
   assign axi_bresp   = (rst_n && bvalid_q) ? bresp_q : RESP_OKAY;
   assign axi_rvalid  = rst_n & rvalid_q;
   assign axi_rlast   = axi_rvalid;
   assign axi_rresp   = (rst_n && rvalid_q) ? rresp_q : RESP_OKAY;
   assign axi_rdata   = (rst_n && rvalid_q && !rd_oor_q) ? sram_rdata : '0;

endmodule : gw5ast_axil_mem_slave
`default_nettype wire

// File: tb/tb_gw5ast_axil_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gw5ast_axil_mem_slave
//  Description : Scoreboard bench for the gw5ast AXI-Lite memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gw5ast_axil_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
   logic [15:0] axi_awaddr, axi_araddr;
   logic [23:0] axi_wdata, axi_rdata;
   logic [3:0]  axi_wstrb;
   logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
   logic        axi_rvalid, axi_rready, axi_rlast;
   logic [1:0]  axi_bresp, axi_rresp;

   int          total = 0;
   int          bad   = 0;
   logic [1:0]  bexp [$];
   logic [25:0] rexp [$];
   logic [23:0] model [0:4095];

   always #5 clk = ~clk;

   gw5ast_axil_mem_slave #(.DATA_WIDTH(24), .ADDR_WIDTH(16), .DEPTH_LOG2(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] d,
                                         input logic [3:0] s);
      logic [23:0] r;
      r = old;
      for (int k = 0; k < 3; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   // Response monitor: pops the scoreboard on every B/R handshake.
   always @(negedge clk) begin
      if (axi_bvalid && axi_bready) begin
         if (bexp.size() == 0) chk("b_unexpected", 32'(axi_bvalid), 32'd0);
         else chk("bresp", 32'(axi_bresp), 32'(bexp.pop_front()));
      end
      if (axi_rvalid && axi_rready) begin
         if (rexp.size() == 0) chk("r_unexpected", 32'(axi_rvalid), 32'd0);
         else begin
            logic [25:0] e;
            e = rexp.pop_front();
            chk("rdata", 32'(axi_rdata), 32'(e[23:0]));
            chk("rresp", 32'(axi_rresp), 32'(e[25:24]));
            chk("rlast", 32'(axi_rlast), 32'd1);
         end
      end
   end

   task automatic send_aw(input logic [15:0] a);
      int n = 0; logic ok = 1'b0;
      axi_awaddr = a; axi_awvalid = 1'b1;
      while (!ok && n <= 50) begin
         @(negedge clk); ok = axi_awready;
         @(posedge clk); #1; n++;
      end
      if (!ok) chk("aw_timeout", 32'(n), 32'd0);
      axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [23:0] d, input logic [3:0] s);
      int n = 0; logic ok = 1'b0;
      axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
      while (!ok && n <= 50) begin
         @(negedge clk); ok = axi_wready;
         @(posedge clk); #1; n++;
      end
      if (!ok) chk("w_timeout", 32'(n), 32'd0);
      axi_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [15:0] a, input logic [23:0] ed, input logic [1:0] er);
      int n = 0; logic ok = 1'b0;
      rexp.push_back({er, ed});
      axi_araddr = a; axi_arvalid = 1'b1;
      while (!ok && n <= 50) begin
         @(negedge clk); ok = axi_arready;
         @(posedge clk); #1; n++;
      end
      if (!ok) chk("ar_timeout", 32'(n), 32'd0);
      axi_arvalid = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      if (a < 16'h1000) send_ar(a, model[a[11:0]], 2'b00);
      else              send_ar(a, 24'h0, 2'b10);
   endtask

   // lead = cycles by which W precedes AW (0 = same cycle)
   task automatic do_write(input logic [15:0] a, input logic [23:0] d, input logic [3:0] s,
                           input int lead);
      if (a < 16'h1000) begin
         bexp.push_back(2'b00);
         model[a[11:0]] = merge(model[a[11:0]], d, s);
      end else begin
         bexp.push_back(2'b10);
      end
      if (lead == 0) begin
         fork
            send_aw(a);
            send_w(d, s);
         join
      end else begin
         fork
            send_w(d, s);
            begin
               repeat (lead - 1) @(posedge clk);
               #1 chk("wready_held", 32'(axi_wready), 32'd0);
               @(posedge clk); #1;
               send_aw(a);
            end
         join
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((bexp.size() != 0 || rexp.size() != 0) && n < 100) begin
         @(posedge clk); n++;
      end
      #1;
      if (n >= 100) chk("drain_timeout", 32'(bexp.size() + rexp.size()), 32'd0);
   endtask

   task automatic wait_bvalid();
      int n = 0;
      while (!axi_bvalid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) chk("bvalid_timeout", 32'(axi_bvalid), 32'd1);
   endtask

   initial begin
      logic [23:0] old;
      rst_n = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
      axi_awaddr = '0; axi_araddr = '0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b1;
      axi_bready = 1'b1; axi_rready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready_low", 32'(axi_awready), 32'd0);
      chk("rst_arready_low", 32'(axi_arready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_awready", 32'(axi_awready), 32'd1);
      chk("rel_wready",  32'(axi_wready),  32'd1);
      chk("rel_arready", 32'(axi_arready), 32'd1);
      chk("rel_bvalid",  32'(axi_bvalid),  32'd0);
      chk("rel_rvalid",  32'(axi_rvalid),  32'd0);

      // AW+W same cycle, then latency checks
      do_write(16'h0010, 24'hABCDEF, 4'b0111, 0);
      chk("b_lat_early", 32'(axi_bvalid), 32'd0);
      @(posedge clk); #1;
      chk("b_lat", 32'(axi_bvalid), 32'd1);
      wait_done();
      rd(16'h0010);
      chk("r_lat", 32'(axi_rvalid), 32'd1);
      wait_done();

      // W leads AW by 3 cycles, then partial-strobe write
      do_write(16'h0020, 24'h5A5A5A, 4'b0111, 3);
      wait_done();
      do_write(16'h0010, 24'h123456, 4'b0010, 0);
      wait_done();
      rd(16'h0010);
      wait_done();
      rd(16'h0020);
      wait_done();

      // Out-of-range and empty strobe
      do_write(16'h0000, 24'h555555, 4'b0111, 0);
      wait_done();
      do_write(16'h1000, 24'h777777, 4'b0111, 0);
      wait_done();
      rd(16'h0000);
      wait_done();
      rd(16'hFFFF);
      wait_done();
      do_write(16'h0010, 24'hFFFFFF, 4'b0000, 0);
      wait_done();
      rd(16'h0010);
      wait_done();

      // B backpressure
      axi_bready = 1'b0;
      do_write(16'h0040, 24'h0F0F0F, 4'b0111, 0);
      wait_bvalid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_bvalid",  32'(axi_bvalid),  32'd1);
         chk("bp_bresp",   32'(axi_bresp),   32'd0);
         chk("bp_awready", 32'(axi_awready), 32'd0);
      end
      axi_bready = 1'b1;
      @(posedge clk); #1;
      chk("bp_b_single", 32'(axi_bvalid), 32'd0);
      wait_done();

      // R backpressure
      axi_rready = 1'b0;
      rd(16'h0040);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_rvalid",  32'(axi_rvalid),  32'd1);
         chk("bp_rdata",   32'(axi_rdata),   32'h000F0F0F);
         chk("bp_arready", 32'(axi_arready), 32'd0);
      end
      axi_rready = 1'b1;
      @(posedge clk); #1;
      chk("bp_r_single", 32'(axi_rvalid), 32'd0);
      wait_done();

      // Collision: AR handshake on the commit edge returns old data
      do_write(16'h0005, 24'h000AAA, 4'b0111, 0);
      wait_done();
      old = model[5];
      model[5] = 24'h000111;
      bexp.push_back(2'b00);
      fork
         send_aw(16'h0005);
         send_w(24'h000111, 4'b0111);
         begin
            @(posedge clk); #1;
            send_ar(16'h0005, old, 2'b00);
         end
      join
      wait_done();
      rd(16'h0005);
      wait_done();

      // Reset with a write response pending: response is dropped
      axi_bready = 1'b0;
      do_write(16'h0030, 24'h222222, 4'b0111, 0);
      wait_bvalid();
      rst_n = 1'b0;
      #1 chk("rst_bvalid_gated", 32'(axi_bvalid), 32'd0);
      bexp.delete();
      @(posedge clk); #1;
      chk("rst_bvalid_next", 32'(axi_bvalid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      axi_bready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_resp_after_rst", 32'(axi_bvalid), 32'd0);
      rd(16'h0030);
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_gw5ast_axil_mem_slave
`default_nettype wire
